// File: rtl/apb_arbiter.sv
// Round-robin arbiter that shares one APB completer bus between NUM_MASTERS
// APB requesters. The granted transfer is replayed on the shared bus, and the
// response is routed back to the granted requester only.
module apb_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_BITS   = 32,
    parameter int unsigned DATA_BITS   = 32
) (
    input  logic                                   apb_clock,
    input  logic                                   reset_n,
    input  logic [NUM_MASTERS-1:0]                 m_psel,
    input  logic [NUM_MASTERS-1:0]                 m_penable,
    input  logic [NUM_MASTERS-1:0]                 m_pwrite,
    input  logic [NUM_MASTERS*ADDR_BITS-1:0]       m_paddr,
    input  logic [NUM_MASTERS*DATA_BITS-1:0]       m_pwdata,
    input  logic [NUM_MASTERS*(DATA_BITS/8)-1:0]   m_pstrb,
    input  logic [NUM_MASTERS*3-1:0]               m_pprot,
    output logic [NUM_MASTERS-1:0]                 m_pready,
    output logic [NUM_MASTERS-1:0]                 m_pslverr,
    output logic [DATA_BITS-1:0]                   m_prdata,
    output logic                                   apb_psel,
    output logic                                   apb_penable,
    output logic                                   apb_pwrite,
    output logic [ADDR_BITS-1:0]                   apb_paddr,
    output logic [DATA_BITS-1:0]                   apb_pwdata,
    output logic [DATA_BITS/8-1:0]                 apb_pstrb,
    output logic [2:0]                             apb_pprot,
    input  logic                                   apb_pready,
    input  logic                                   apb_pslverr,
    input  logic [DATA_BITS-1:0]                   apb_prdata,
    output logic [NUM_MASTERS-1:0]                 arb_grant
);

    localparam int unsigned STRB_BITS = DATA_BITS / 8;
    localparam int unsigned PTR_BITS  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [PTR_BITS-1:0]    last;
    logic [PTR_BITS-1:0]    last_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic                   psel_nxt;
    logic                   penable_nxt;
    logic                   pwrite_nxt;
    logic [ADDR_BITS-1:0]   paddr_nxt;
    logic [DATA_BITS-1:0]   pwdata_nxt;
    logic [STRB_BITS-1:0]   pstrb_nxt;
    logic [2:0]             pprot_nxt;

    logic [NUM_MASTERS-1:0] arb_req;
    logic                   found;
    logic [PTR_BITS-1:0]    winner;
    logic [PTR_BITS-1:0]    pick;
    int unsigned            idx;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic                   sel_pwrite;
    logic [ADDR_BITS-1:0]   sel_paddr;
    logic [DATA_BITS-1:0]   sel_pwdata;
    logic [STRB_BITS-1:0]   sel_pstrb;
    logic [2:0]             sel_pprot;

    // Round-robin pick starting after the last owner; the current owner is
    // masked so a finishing master cannot immediately win again.
    always_comb begin
        arb_req = m_psel & ~arb_grant;
        found   = 1'b0;
        winner  = '0;
        pick    = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx  = (32'(last) + k) % NUM_MASTERS;
            pick = PTR_BITS'(idx);
            if (!found && arb_req[pick]) begin
                found  = 1'b1;
                winner = pick;
            end
        end
        win_onehot = NUM_MASTERS'(1) << winner;
        sel_pwrite = m_pwrite[winner];
        sel_paddr  = m_paddr[32'(winner)*ADDR_BITS +: ADDR_BITS];
        sel_pwdata = m_pwdata[32'(winner)*DATA_BITS +: DATA_BITS];
        sel_pstrb  = m_pstrb[32'(winner)*STRB_BITS +: STRB_BITS];
        sel_pprot  = m_pprot[32'(winner)*3 +: 3];
    end

    // Next-state and next shared-bus values; attributes are captured only at grant.
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        grant_nxt   = arb_grant;
        psel_nxt    = apb_psel;
        penable_nxt = apb_penable;
        pwrite_nxt  = apb_pwrite;
        paddr_nxt   = apb_paddr;
        pwdata_nxt  = apb_pwdata;
        pstrb_nxt   = apb_pstrb;
        pprot_nxt   = apb_pprot;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt  = ST_SETUP;
                    grant_nxt  = win_onehot;
                    last_nxt   = winner;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = sel_pwrite;
                    paddr_nxt  = sel_paddr;
                    pwdata_nxt = sel_pwdata;
                    pstrb_nxt  = sel_pstrb;
                    pprot_nxt  = sel_pprot;
                end
            end
            ST_SETUP: begin
                state_nxt   = ST_ACCESS;
                penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (apb_pready) begin
                    if (found) begin
                        state_nxt   = ST_SETUP;
                        grant_nxt   = win_onehot;
                        last_nxt    = winner;
                        psel_nxt    = 1'b1;
                        penable_nxt = 1'b0;
                        pwrite_nxt  = sel_pwrite;
                        paddr_nxt   = sel_paddr;
                        pwdata_nxt  = sel_pwdata;
                        pstrb_nxt   = sel_pstrb;
                        pprot_nxt   = sel_pprot;
                    end else begin
                        state_nxt   = ST_IDLE;
                        grant_nxt   = '0;
                        psel_nxt    = 1'b0;
                        penable_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                grant_nxt   = '0;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer and shared-bus registers; reset parks the pointer on the
    // last master so master 0 wins the first arbitration.
    always_ff @(posedge apb_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last        <= PTR_BITS'(NUM_MASTERS - 1);
            arb_grant   <= '0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            apb_pstrb   <= '0;
            apb_pprot   <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            arb_grant   <= grant_nxt;
            apb_psel    <= psel_nxt;
            apb_penable <= penable_nxt;
            apb_pwrite  <= pwrite_nxt;
            apb_paddr   <= paddr_nxt;
            apb_pwdata  <= pwdata_nxt;
            apb_pstrb   <= pstrb_nxt;
            apb_pprot   <= pprot_nxt;
        end
    end

    // Response routing: zero-latency, gated by the owner's own access phase.
    assign m_pready  = {NUM_MASTERS{(state == ST_ACCESS) && apb_pready}} & arb_grant & m_penable;
    assign m_pslverr = m_pready & {NUM_MASTERS{apb_pslverr}};
    assign m_prdata  = apb_prdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized
// request bursts checked against a transaction-level round-robin model.
module tb_apb_arbiter;

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic                 apb_clock = 1'b0;
    logic                 reset_n;
    logic [NM-1:0]        m_psel;
    logic [NM-1:0]        m_penable;
    logic [NM-1:0]        m_pwrite;
    logic [NM*AW-1:0]     m_paddr;
    logic [NM*DW-1:0]     m_pwdata;
    logic [NM*SW-1:0]     m_pstrb;
    logic [NM*3-1:0]      m_pprot;
    logic [NM-1:0]        m_pready;
    logic [NM-1:0]        m_pslverr;
    logic [DW-1:0]        m_prdata;
    logic                 apb_psel;
    logic                 apb_penable;
    logic                 apb_pwrite;
    logic [AW-1:0]        apb_paddr;
    logic [DW-1:0]        apb_pwdata;
    logic [SW-1:0]        apb_pstrb;
    logic [2:0]           apb_pprot;
    logic                 apb_pready = 1'b0;
    logic                 apb_pslverr = 1'b0;
    logic [DW-1:0]        apb_prdata = '0;
    logic [NM-1:0]        arb_grant;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [2:0]    p;
    } txn_t;

    typedef struct {
        logic [NM-1:0] grant;
        txn_t          t;
        logic [NM-1:0] rdy;
        logic [NM-1:0] err;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        int            waits;
        int            cyc;
    } mon_t;

    txn_t txq[NM][$];
    txn_t expq[NM][$];
    mon_t monq[$];
    logic [NM-1:0] done_f;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int mdl_last;

    logic          cmp_rand = 1'b0;
    int            dir_waits = 0;
    logic [DW-1:0] dir_rdata = '0;
    logic [AW-1:0] dir_err_addr = '1;
    int            cw = 0;
    logic [DW-1:0] crd = '0;
    logic          cerr = 1'b0;
    int            ccnt = 0;
    logic          cstarted = 1'b0;

    logic          s_psel, s_pen, s_pwrite;
    logic [NM-1:0] s_grant, s_pready, s_pslverr;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata, s_prdata;
    logic [SW-1:0] s_pstrb;

    apb_arbiter #(.NUM_MASTERS(NM), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .apb_clock(apb_clock), .reset_n(reset_n),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_pprot(apb_pprot), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
        .apb_prdata(apb_prdata), .arb_grant(arb_grant)
    );

    always #5 apb_clock = ~apb_clock;

    // Completer: inserts wait states, then returns data/error for one cycle.
    always @(negedge apb_clock) begin
        if (apb_psel && apb_penable) begin
            if (!cstarted) begin
                cstarted = 1'b1;
                ccnt = 0;
                if (cmp_rand) begin
                    cw   = int'($urandom_range(0, 3));
                    crd  = $urandom;
                    cerr = 1'($urandom_range(0, 1));
                end else begin
                    cw   = dir_waits;
                    crd  = dir_rdata;
                    cerr = (apb_paddr == dir_err_addr);
                end
            end
            if (ccnt >= cw) begin
                apb_pready  = 1'b1;
                apb_prdata  = crd;
                apb_pslverr = cerr;
            end else begin
                apb_pready  = 1'b0;
                apb_prdata  = $urandom;
                apb_pslverr = 1'($urandom_range(0, 1));
                ccnt++;
            end
        end else begin
            cstarted    = 1'b0;
            apb_pready  = 1'b0;
            apb_pslverr = 1'b0;
        end
    end

    task automatic drive(input int i, input txn_t t);
        m_pwrite[i]           = t.w;
        m_paddr[i*AW +: AW]   = t.a;
        m_pwdata[i*DW +: DW]  = t.d;
        m_pstrb[i*SW +: SW]   = t.s;
        m_pprot[i*3 +: 3]     = t.p;
    endtask

    // One cycle: sample outputs mid-cycle, log completions, advance requesters.
    task automatic step();
        logic [NM-1:0] rdy;
        mon_t m;
        txn_t t;
        @(negedge apb_clock);
        #1;
        cyc++;
        s_psel = apb_psel; s_pen = apb_penable; s_grant = arb_grant;
        s_paddr = apb_paddr; s_pwrite = apb_pwrite; s_pwdata = apb_pwdata;
        s_pstrb = apb_pstrb; s_pready = m_pready; s_pslverr = m_pslverr;
        s_prdata = m_prdata;
        rdy = m_pready;
        if (apb_psel && apb_penable && apb_pready) begin
            m.grant = arb_grant;
            m.t.w = apb_pwrite; m.t.a = apb_paddr; m.t.d = apb_pwdata;
            m.t.s = apb_pstrb; m.t.p = apb_pprot;
            m.rdy = m_pready; m.err = m_pslverr; m.rdata = m_prdata;
            m.exp_rd = crd; m.exp_err = cerr; m.waits = cw; m.cyc = cyc;
            monq.push_back(m);
        end
        for (int i = 0; i < int'(NM); i++) begin
            if (done_f[i]) begin
                done_f[i] = 1'b0;
                m_psel[i] = 1'b0;
                m_penable[i] = 1'b0;
            end
            if (rdy[i]) begin
                done_f[i] = 1'b1;
            end else if (!m_psel[i] && txq[i].size() > 0) begin
                t = txq[i].pop_front();
                drive(i, t);
                m_psel[i] = 1'b1;
                m_penable[i] = 1'b0;
            end else if (m_psel[i] && !m_penable[i]) begin
                m_penable[i] = 1'b1;
            end
        end
    endtask

    task automatic clear_reqs();
        m_psel = '0;
        m_penable = '0;
        done_f = '0;
        for (int i = 0; i < int'(NM); i++) begin
            txq[i].delete();
            expq[i].delete();
        end
    endtask

    task automatic apply_reset();
        @(negedge apb_clock);
        reset_n = 1'b0;
        clear_reqs();
        repeat (2) @(negedge apb_clock);
        #1 reset_n = 1'b1;
        monq.delete();
    endtask

    function automatic txn_t mk(input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [SW-1:0] s,
                                input logic [2:0] p);
        txn_t t;
        t.w = w; t.a = a; t.d = d; t.s = s; t.p = p;
        return t;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge apb_clock);
        #2;
        nvec++;
        if ({apb_psel, apb_penable, apb_pwrite, arb_grant} !== '0) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b want 0", {apb_psel, apb_penable, apb_pwrite, arb_grant});
        end
        nvec++;
        if ({apb_paddr, apb_pwdata, apb_pstrb, apb_pprot} !== '0) begin
            nerr++;
            $display("FAIL reset_attr: got %h want 0", {apb_paddr, apb_pwdata, apb_pstrb, apb_pprot});
        end
        @(negedge apb_clock);
        #1 reset_n = 1'b1;
        repeat (2) step();
        nvec++;
        if ({s_psel, s_pen, s_grant, s_pready} !== '0) begin
            nerr++;
            $display("FAIL reset_idle: got %b want 0", {s_psel, s_pen, s_grant, s_pready});
        end
    endtask

    task automatic test_single();
        dir_waits = 0;
        txq[0].push_back(mk(1'b1, 32'h4000_0010, 32'hA5A5_0001, 4'hF, 3'd0));
        step();
        nvec++;
        if (s_psel !== 1'b0) begin nerr++; $display("FAIL single_c0_psel: got %b want 0", s_psel); end
        step();
        nvec++;
        if ({s_psel, s_pen, s_grant} !== {1'b1, 1'b0, 3'b001}) begin
            nerr++; $display("FAIL single_c1: got %b want 10001", {s_psel, s_pen, s_grant});
        end
        nvec++;
        if ({s_pwrite, s_paddr, s_pwdata, s_pstrb} !== {1'b1, 32'h4000_0010, 32'hA5A5_0001, 4'hF}) begin
            nerr++; $display("FAIL single_attr: got %h want 140000010a5a50001f", {s_pwrite, s_paddr, s_pwdata, s_pstrb});
        end
        step();
        nvec++;
        if ({s_psel, s_pen, s_pready} !== {1'b1, 1'b1, 3'b001}) begin
            nerr++; $display("FAIL single_c2: got %b want 11001", {s_psel, s_pen, s_pready});
        end
        step();
        nvec++;
        if ({s_psel, s_grant, s_pready} !== '0) begin
            nerr++; $display("FAIL single_c3: got %b want 0", {s_psel, s_grant, s_pready});
        end
    endtask

    task automatic test_wait_states();
        int nwait = 0;
        logic got = 1'b0;
        dir_waits = 3;
        dir_rdata = 32'h1234_5678;
        txq[1].push_back(mk(1'b0, 32'h4000_0020, 32'h0, 4'h0, 3'd2));
        step();
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (s_psel && s_pen) begin
                nvec++;
                if (s_paddr !== 32'h4000_0020) begin
                    nerr++; $display("FAIL wait_addr_stable: got %h want 40000020", s_paddr);
                end
                if (s_pready[1]) begin
                    got = 1'b1;
                    nvec++;
                    if (nwait !== 3) begin nerr++; $display("FAIL wait_count: got %0d want 3", nwait); end
                    nvec++;
                    if ({s_pready, s_prdata} !== {3'b010, 32'h1234_5678}) begin
                        nerr++; $display("FAIL wait_rdata: got %h want 212345678", {s_pready, s_prdata});
                    end
                end else begin
                    nwait++;
                end
            end
        end
        nvec++;
        if (!got) begin nerr++; $display("FAIL wait_timeout: got no ready want ready"); end
        repeat (2) step();
    endtask

    task automatic test_contention();
        logic [NM-1:0] eg [4];
        eg[0] = 3'b001; eg[1] = 3'b010; eg[2] = 3'b001; eg[3] = 3'b010;
        apply_reset();
        dir_waits = 0;
        txq[0].push_back(mk(1'b1, 32'h100, 32'h11, 4'h1, 3'd0));
        txq[0].push_back(mk(1'b1, 32'h104, 32'h12, 4'h3, 3'd1));
        txq[1].push_back(mk(1'b0, 32'h200, 32'h21, 4'h7, 3'd2));
        txq[1].push_back(mk(1'b1, 32'h204, 32'h22, 4'hF, 3'd3));
        for (int n = 0; n < 40 && monq.size() < 4; n++) step();
        nvec++;
        if (monq.size() != 4) begin
            nerr++; $display("FAIL contention_count: got %0d want 4", monq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                nvec++;
                if ({monq[k].grant, monq[k].rdy} !== {eg[k], eg[k]}) begin
                    nerr++; $display("FAIL contention_order[%0d]: got %b want %b", k, {monq[k].grant, monq[k].rdy}, {eg[k], eg[k]});
                end
                if (k > 0) begin
                    nvec++;
                    if (monq[k].cyc - monq[k-1].cyc !== 2) begin
                        nerr++; $display("FAIL contention_gap[%0d]: got %0d want 2", k, monq[k].cyc - monq[k-1].cyc);
                    end
                end
            end
            nvec++;
            if (monq[3].t.a !== 32'h204) begin
                nerr++; $display("FAIL contention_addr: got %h want 204", monq[3].t.a);
            end
        end
        repeat (2) step();
    endtask

    task automatic test_error();
        logic seen = 1'b0;
        monq.delete();
        dir_waits = 1;
        dir_err_addr = 32'h4000_0100;
        txq[0].push_back(mk(1'b1, 32'h4000_0200, 32'h5, 4'hF, 3'd0));
        txq[1].push_back(mk(1'b0, 32'h4000_0100, 32'h0, 4'h0, 3'd0));
        for (int n = 0; n < 30 && monq.size() < 2; n++) begin
            step();
            nvec++;
            if (s_pslverr[0] !== 1'b0) begin nerr++; $display("FAIL error_m0: got %b want 0", s_pslverr[0]); end
            if (s_pready[1]) begin
                seen = 1'b1;
                nvec++;
                if (s_pslverr !== 3'b010) begin nerr++; $display("FAIL error_m1: got %b want 010", s_pslverr); end
            end
        end
        nvec++;
        if (!seen) begin nerr++; $display("FAIL error_timeout: got no m1 ready want ready"); end
        dir_err_addr = '1;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        logic hit = 1'b0;
        dir_waits = 5;
        txq[0].push_back(mk(1'b1, 32'h300, 32'h33, 4'hF, 3'd0));
        for (int n = 0; n < 10 && !hit; n++) begin
            step();
            hit = s_psel && s_pen;
        end
        #2 reset_n = 1'b0;
        #1;
        nvec++;
        if ({apb_psel, apb_penable, arb_grant, m_pready} !== '0) begin
            nerr++; $display("FAIL resetmid_async: got %b want 0", {apb_psel, apb_penable, arb_grant, m_pready});
        end
        clear_reqs();
        @(negedge apb_clock);
        #1 reset_n = 1'b1;
        monq.delete();
        dir_waits = 0;
        txq[1].push_back(mk(1'b0, 32'h310, 32'h0, 4'h0, 3'd0));
        txq[0].push_back(mk(1'b0, 32'h320, 32'h0, 4'h0, 3'd0));
        for (int n = 0; n < 30 && monq.size() < 2; n++) step();
        nvec++;
        if (monq.size() != 2) begin
            nerr++; $display("FAIL resetmid_count: got %0d want 2", monq.size());
        end else if ({monq[0].grant, monq[1].grant} !== {3'b001, 3'b010}) begin
            nerr++; $display("FAIL resetmid_priority: got %b want 001010", {monq[0].grant, monq[1].grant});
        end
        repeat (2) step();
    endtask

    task automatic test_drop();
        logic hit = 1'b0;
        monq.delete();
        dir_waits = 2;
        txq[0].push_back(mk(1'b1, 32'h400, 32'h44, 4'hF, 3'd0));
        for (int n = 0; n < 10 && !hit; n++) begin
            step();
            hit = s_psel && s_pen;
        end
        m_psel[0] = 1'b0;
        m_penable[0] = 1'b0;
        for (int n = 0; n < 10 && monq.size() < 1; n++) begin
            step();
            nvec++;
            if (s_pready !== '0) begin nerr++; $display("FAIL drop_ready: got %b want 000", s_pready); end
        end
        nvec++;
        if (monq.size() != 1) begin nerr++; $display("FAIL drop_complete: got %0d want 1", monq.size()); end
        step();
        nvec++;
        if ({s_psel, s_grant} !== '0) begin nerr++; $display("FAIL drop_idle: got %b want 0", {s_psel, s_grant}); end
    endtask

    task automatic test_fairness();
        logic hit = 1'b0;
        monq.delete();
        dir_waits = 2;
        for (int k = 0; k < 3; k++) txq[0].push_back(mk(1'b1, 32'h500 + 32'(k), 32'h0, 4'hF, 3'd0));
        for (int n = 0; n < 10 && !hit; n++) begin
            step();
            hit = s_psel && s_pen && (s_grant == 3'b001);
        end
        txq[1].push_back(mk(1'b0, 32'h600, 32'h0, 4'h0, 3'd0));
        for (int n = 0; n < 60 && monq.size() < 4; n++) step();
        nvec++;
        if (monq.size() != 4) begin
            nerr++; $display("FAIL fair_count: got %0d want 4", monq.size());
        end else if ({monq[0].grant, monq[1].grant, monq[2].grant, monq[3].grant} !==
                     {3'b001, 3'b010, 3'b001, 3'b001}) begin
            nerr++; $display("FAIL fair_order: got %b want 001010001001",
                             {monq[0].grant, monq[1].grant, monq[2].grant, monq[3].grant});
        end
        repeat (2) step();
    endtask

    task automatic test_random();
        int pend[NM];
        int order[$];
        int cur, total, idx, gap;
        logic picked;
        txn_t t, e;
        logic [NM-1:0] eg;
        apply_reset();
        cmp_rand = 1'b1;
        mdl_last = int'(NM) - 1;
        for (int r = 0; r < 25; r++) begin
            total = 0;
            for (int i = 0; i < int'(NM); i++) begin
                pend[i] = int'($urandom_range(0, 2));
                total += pend[i];
            end
            if (total == 0) begin
                pend[$urandom_range(0, NM-1)] = 1;
                total = 1;
            end
            for (int i = 0; i < int'(NM); i++) begin
                for (int j = 0; j < pend[i]; j++) begin
                    t = mk(1'($urandom_range(0, 1)), $urandom, $urandom,
                           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
                    txq[i].push_back(t);
                    expq[i].push_back(t);
                end
            end
            // expected service order: cyclic scan from the master after the last winner
            order.delete();
            cur = mdl_last;
            for (int n = 0; n < total; n++) begin
                picked = 1'b0;
                for (int k = 1; k <= int'(NM); k++) begin
                    idx = (cur + k) % int'(NM);
                    if (!picked && pend[idx] > 0) begin
                        picked = 1'b1;
                        order.push_back(idx);
                        pend[idx]--;
                        cur = idx;
                    end
                end
            end
            mdl_last = cur;
            monq.delete();
            for (int n = 0; n < 40 * total && monq.size() < total; n++) step();
            nvec++;
            if (monq.size() != total) begin
                nerr++;
                $display("FAIL rand_count[%0d]: got %0d want %0d", r, monq.size(), total);
                apply_reset();
                mdl_last = int'(NM) - 1;
            end else begin
                for (int k = 0; k < total; k++) begin
                    eg = NM'(1) << order[k];
                    e = expq[order[k]].pop_front();
                    nvec++;
                    if ({monq[k].grant, monq[k].rdy} !== {eg, eg}) begin
                        nerr++; $display("FAIL rand_grant[%0d.%0d]: got %b want %b", r, k, {monq[k].grant, monq[k].rdy}, {eg, eg});
                    end
                    nvec++;
                    if ({monq[k].t.w, monq[k].t.a, monq[k].t.d, monq[k].t.s, monq[k].t.p} !== {e.w, e.a, e.d, e.s, e.p}) begin
                        nerr++; $display("FAIL rand_attr[%0d.%0d]: got %h want %h", r, k,
                                         {monq[k].t.w, monq[k].t.a, monq[k].t.d, monq[k].t.s, monq[k].t.p}, {e.w, e.a, e.d, e.s, e.p});
                    end
                    nvec++;
                    if ({monq[k].rdata, monq[k].err} !== {monq[k].exp_rd, (monq[k].exp_err ? eg : NM'(0))}) begin
                        nerr++; $display("FAIL rand_resp[%0d.%0d]: got %h want %h", r, k, {monq[k].rdata, monq[k].err},
                                         {monq[k].exp_rd, (monq[k].exp_err ? eg : NM'(0))});
                    end
                    if (k > 0) begin
                        gap = 2 + monq[k].waits + ((order[k] == order[k-1]) ? 1 : 0);
                        nvec++;
                        if (monq[k].cyc - monq[k-1].cyc !== gap) begin
                            nerr++; $display("FAIL rand_gap[%0d.%0d]: got %0d want %0d", r, k, monq[k].cyc - monq[k-1].cyc, gap);
                        end
                    end
                end
            end
        end
        cmp_rand = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        reset_n   = 1'b0;
        m_psel    = '0;
        m_penable = '0;
        m_pwrite  = '0;
        m_paddr   = '0;
        m_pwdata  = '0;
        m_pstrb   = '0;
        m_pprot   = '0;
        done_f    = '0;
        test_reset();
        test_single();
        test_wait_states();
        test_contention();
        test_error();
        test_reset_mid();
        test_drop();
        test_fairness();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
